// File: rtl/text_overlay_pkg.sv
// Shared constants, commit FSM encoding and config sanitising helpers
// for the text overlay controller.
package text_overlay_pkg;

    localparam int CHAR_W    = 8;
    localparam int CHAR_H    = 8;
    localparam int MAX_CHARS = 16;
    localparam int IDX_W     = $clog2(MAX_CHARS);
    localparam int CODE_W    = 6;
    localparam int LEN_W     = IDX_W + 1;
    localparam int SCL_W     = 4;

    localparam logic [SCL_W-1:0] SCALE_MIN = SCL_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_CHARS);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SWAP
    } commit_st_e;

    function automatic logic [SCL_W-1:0] fix_scale(input logic [SCL_W-1:0] s);
        return (s == '0) ? SCALE_MIN : s;
    endfunction

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > LEN_MAX) ? LEN_MAX : l;
    endfunction

endpackage

// File: rtl/text_overlay_if.sv
// Label write / commit handshake into the overlay controller.
// cfg_blink is present only when TEXT_BLINK_EN is defined.
interface text_overlay_if;
    import text_overlay_pkg::*;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [CODE_W-1:0] wr_code;
    logic [LEN_W-1:0]  cfg_len;
    logic [10:0]       cfg_origin_x;
    logic [9:0]        cfg_origin_y;
    logic [3:0]        cfg_scale_x;
    logic [3:0]        cfg_scale_y;
`ifdef TEXT_BLINK_EN
    logic              cfg_blink;
`endif
    logic              commit_req;
    logic              commit_ack;
    logic              busy;

    modport master (
        output wr_en, wr_idx, wr_code,
        output cfg_len, cfg_origin_x, cfg_origin_y,
        output cfg_scale_x, cfg_scale_y,
`ifdef TEXT_BLINK_EN
        output cfg_blink,
`endif
        output commit_req,
        input  commit_ack, busy
    );

    modport slave (
        input  wr_en, wr_idx, wr_code,
        input  cfg_len, cfg_origin_x, cfg_origin_y,
        input  cfg_scale_x, cfg_scale_y,
`ifdef TEXT_BLINK_EN
        input  cfg_blink,
`endif
        input  commit_req,
        output commit_ack, busy
    );

endinterface

// File: rtl/cell_scan_counter.sv
// Steps sub-pixel / column / cell-x across one label line; outputs are the
// values for the pixel presented this cycle.
module cell_scan_counter
    import text_overlay_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             start_i,
    input  logic [10:0]      origin_x_i,
    input  logic [3:0]       scale_x_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             run_o,
    output logic [LEN_W-1:0] col_o,
    output logic [10:0]      cell_x_o
);

    logic [6:0]       span;
    logic [6:0]       sub_q, sub_d;
    logic [LEN_W-1:0] col_q;
    logic [10:0]      cx_q;
    logic             run_q;

    assign span = 7'(scale_x_i * CHAR_W);

    always_comb begin
        run_o    = 1'b0;
        col_o    = col_q;
        cell_x_o = cx_q;
        sub_d    = sub_q;
        if (start_i) begin
            run_o    = 1'b1;
            col_o    = '0;
            cell_x_o = origin_x_i;
            sub_d    = '0;
        end else if (run_q && valid_i) begin
            run_o = 1'b1;
            if (sub_q == span - 7'd1) begin
                sub_d    = '0;
                col_o    = col_q + LEN_W'(1);
                cell_x_o = cx_q + {4'b0, span};
            end else begin
                sub_d = sub_q + 7'd1;
            end
        end
    end

    // Scanning stops once the column walks past the label or video ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
            col_q <= '0;
            sub_q <= '0;
            cx_q  <= '0;
        end else begin
            run_q <= run_o && (col_o < len_i);
            col_q <= col_o;
            sub_q <= sub_d;
            cx_q  <= cell_x_o;
        end
    end

endmodule

// File: rtl/text_overlay_ctrl.sv
// Text overlay sequencer: shadow/active label buffers, frame-synchronous
// commit FSM and per-pixel glyph selection. Optional blink: TEXT_BLINK_EN.
module text_overlay_ctrl
    import text_overlay_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    text_overlay_if.slave       bus,
    input  logic                frame_start,
    input  logic [10:0]         vga_x,
    input  logic [9:0]          vga_y,
    input  logic                vga_valid,
    output logic                rend_enable,
    output logic [CODE_W+2:0]   char_addr_offset,
    output logic [10:0]         top_left_x,
    output logic [9:0]          top_left_y,
    output logic [3:0]          scale_x_o,
    output logic [3:0]          scale_y_o
);

    commit_st_e state_q, state_d;
    logic [MAX_CHARS-1:0][CODE_W-1:0] shadow_q, active_q;
    logic [LEN_W-1:0] sh_len_q, len_q;
    logic [10:0]      sh_ox_q, ox_q;
    logic [9:0]       sh_oy_q, oy_q;
    logic [3:0]       sh_sx_q, sx_q, sh_sy_q, sy_q;
    logic             ack_q, wr_ok, latch, swap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        wr_ok   = 1'b0;
        latch   = 1'b0;
        swap    = 1'b0;
        unique case (state_q)
            IDLE: begin
                wr_ok = bus.wr_en;
                latch = bus.commit_req;
                if (bus.commit_req) state_d = ARMED;
            end
            ARMED: if (frame_start) state_d = SWAP;
            SWAP: begin
                swap    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.commit_ack = ack_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
            sh_len_q <= '0;
            len_q    <= '0;
            sh_ox_q  <= '0;
            ox_q     <= '0;
            sh_oy_q  <= '0;
            oy_q     <= '0;
            sh_sx_q  <= SCALE_MIN;
            sx_q     <= SCALE_MIN;
            sh_sy_q  <= SCALE_MIN;
            sy_q     <= SCALE_MIN;
            ack_q    <= 1'b0;
        end else begin
            ack_q <= swap;
            if (wr_ok) shadow_q[bus.wr_idx] <= bus.wr_code;
            if (latch) begin
                sh_len_q <= clamp_len(bus.cfg_len);
                sh_ox_q  <= bus.cfg_origin_x;
                sh_oy_q  <= bus.cfg_origin_y;
                sh_sx_q  <= fix_scale(bus.cfg_scale_x);
                sh_sy_q  <= fix_scale(bus.cfg_scale_y);
            end
            if (swap) begin
                active_q <= shadow_q;
                len_q    <= sh_len_q;
                ox_q     <= sh_ox_q;
                oy_q     <= sh_oy_q;
                sx_q     <= sh_sx_q;
                sy_q     <= sh_sy_q;
            end
        end
    end

    logic blank;
`ifdef TEXT_BLINK_EN
    logic       sh_blink_q, blink_q;
    logic [5:0] frame_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_blink_q  <= 1'b0;
            blink_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            if (frame_start) frame_cnt_q <= frame_cnt_q + 6'd1;
            if (latch)       sh_blink_q  <= bus.cfg_blink;
            if (swap)        blink_q     <= sh_blink_q;
        end
    end

    assign blank = blink_q && frame_cnt_q[5];
`else
    assign blank = 1'b0;
`endif

    logic [10:0]      band_hi, cell_x;
    logic [LEN_W-1:0] col;
    logic             band, start, run, lit;

    assign band_hi = {1'b0, oy_q} + 11'(sy_q * CHAR_H);
    assign band    = (vga_y >= oy_q) && ({1'b0, vga_y} < band_hi);
    assign start   = vga_valid && band && (vga_x == ox_q);

    cell_scan_counter u_scan (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (vga_valid),
        .start_i    (start),
        .origin_x_i (ox_q),
        .scale_x_i  (sx_q),
        .len_i      (len_q),
        .run_o      (run),
        .col_o      (col),
        .cell_x_o   (cell_x)
    );

    assign lit = run && band && (col < len_q) && !blank;

    logic              rend_q;
    logic [CODE_W+2:0] off_q;
    logic [10:0]       tlx_q;
    logic [9:0]        tly_q;
    logic [3:0]        sxo_q, syo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rend_q <= 1'b0;
            off_q  <= '0;
            tlx_q  <= '0;
            tly_q  <= '0;
            sxo_q  <= '0;
            syo_q  <= '0;
        end else begin
            rend_q <= lit;
            off_q  <= lit ? {active_q[col[IDX_W-1:0]], 3'b000} : '0;
            tlx_q  <= lit ? cell_x : ox_q;
            tly_q  <= oy_q;
            sxo_q  <= sx_q;
            syo_q  <= sy_q;
        end
    end

    assign rend_enable      = rend_q;
    assign char_addr_offset = off_q;
    assign top_left_x       = tlx_q;
    assign top_left_y       = tly_q;
    assign scale_x_o        = sxo_q;
    assign scale_y_o        = syo_q;

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// Scoreboard bench for text_overlay_ctrl: random labels and scan lines
// checked against a pixel-arithmetic reference of the overlay.
module tb_text_overlay_ctrl;
    import text_overlay_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    text_overlay_if bus();
    logic        frame_start;
    logic [10:0] vga_x;
    logic [9:0]  vga_y;
    logic        vga_valid;
    logic        rend_enable;
    logic [8:0]  char_addr_offset;
    logic [10:0] top_left_x;
    logic [9:0]  top_left_y;
    logic [3:0]  scale_x_o, scale_y_o;

    text_overlay_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .frame_start      (frame_start),
        .vga_x            (vga_x),
        .vga_y            (vga_y),
        .vga_valid        (vga_valid),
        .rend_enable      (rend_enable),
        .char_addr_offset (char_addr_offset),
        .top_left_x       (top_left_x),
        .top_left_y       (top_left_y),
        .scale_x_o        (scale_x_o),
        .scale_y_o        (scale_y_o)
    );

    typedef struct {
        int x, y, en, off, tlx, tly, sx, sy, busy, ack;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;

    // Reference state: pending label/config and the label on screen.
    int m_state, fcnt, run_x0;
    bit prev_valid;
    int sh[MAX_CHARS];
    int act[MAX_CHARS];
    int s_len, s_ox, s_oy, s_sx, s_sy, s_blink;
    int a_len, a_ox, a_oy, a_sx, a_sy, a_blink;

    function automatic void chk(string nm, int x, int y, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s x=%0d y=%0d got=%0d want=%0d", nm, x, y, got, want);
        end
    endfunction

    task automatic model_reset();
        m_state = 0; fcnt = 0; run_x0 = 0; prev_valid = 0;
        for (int i = 0; i < MAX_CHARS; i++) begin
            sh[i] = 0;
            act[i] = 0;
        end
        s_len = 0; s_ox = 0; s_oy = 0; s_sx = 1; s_sy = 1; s_blink = 0;
        a_len = 0; a_ox = 0; a_oy = 0; a_sx = 1; a_sy = 1; a_blink = 0;
    endtask

    task automatic tick();
        exp_t e;
        int x, y, w, col;
        @(posedge clk);
        x = int'(vga_x);
        y = int'(vga_y);
        if (vga_valid && !prev_valid) run_x0 = x;
        prev_valid = vga_valid;
        w = 8 * a_sx;
        e.x = x; e.y = y; e.en = 0; e.off = 0; e.tlx = a_ox;
        e.tly = a_oy; e.sx = a_sx; e.sy = a_sy;
        e.ack = (m_state == 2) ? 1 : 0;
        if (vga_valid && y >= a_oy && y < a_oy + 8 * a_sy &&
            run_x0 <= a_ox && x >= a_ox) begin
            col = (x - a_ox) / w;
            if (col < a_len && !(a_blink != 0 && fcnt >= 32)) begin
                e.en = 1;
                e.off = act[col] * 8;
                e.tlx = a_ox + col * w;
            end
        end
        case (m_state)
            0: begin
                if (bus.wr_en) sh[bus.wr_idx] = int'(bus.wr_code);
                if (bus.commit_req) begin
                    s_len = (int'(bus.cfg_len) > MAX_CHARS) ? MAX_CHARS : int'(bus.cfg_len);
                    s_ox = int'(bus.cfg_origin_x);
                    s_oy = int'(bus.cfg_origin_y);
                    s_sx = (bus.cfg_scale_x == 0) ? 1 : int'(bus.cfg_scale_x);
                    s_sy = (bus.cfg_scale_y == 0) ? 1 : int'(bus.cfg_scale_y);
`ifdef TEXT_BLINK_EN
                    s_blink = int'(bus.cfg_blink);
`endif
                    m_state = 1;
                end
            end
            1: if (frame_start) m_state = 2;
            default: begin
                act = sh;
                a_len = s_len; a_ox = s_ox; a_oy = s_oy;
                a_sx = s_sx; a_sy = s_sy; a_blink = s_blink;
                m_state = 0;
            end
        endcase
        if (frame_start) fcnt = (fcnt + 1) % 64;
        e.busy = (m_state != 0) ? 1 : 0;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("rend_enable", e.x, e.y, int'(rend_enable), e.en);
            chk("char_addr_offset", e.x, e.y, int'(char_addr_offset), e.off);
            chk("top_left_x", e.x, e.y, int'(top_left_x), e.tlx);
            chk("top_left_y", e.x, e.y, int'(top_left_y), e.tly);
            chk("scale_x_o", e.x, e.y, int'(scale_x_o), e.sx);
            chk("scale_y_o", e.x, e.y, int'(scale_y_o), e.sy);
            chk("busy", e.x, e.y, int'(bus.busy), e.busy);
            chk("commit_ack", e.x, e.y, int'(bus.commit_ack), e.ack);
        end
    end

    task automatic step();
        tick();
        @(negedge clk);
        bus.wr_en = 0;
        bus.commit_req = 0;
        frame_start = 0;
    endtask

    task automatic wr(input int idx, input int code);
        bus.wr_en = 1;
        bus.wr_idx = IDX_W'(idx);
        bus.wr_code = CODE_W'(code);
        step();
    endtask

    task automatic commit(input int len, input int ox, input int oy,
                          input int sx, input int sy);
        bus.commit_req = 1;
        bus.cfg_len = LEN_W'(len);
        bus.cfg_origin_x = 11'(ox);
        bus.cfg_origin_y = 10'(oy);
        bus.cfg_scale_x = 4'(sx);
        bus.cfg_scale_y = 4'(sy);
        step();
    endtask

    task automatic frame();
        frame_start = 1;
        step();
        step();
        step();
    endtask

    task automatic scan(input int y, input int x0, input int n);
        for (int i = 0; i < n; i++) begin
            vga_valid = 1;
            vga_y = 10'(y);
            vga_x = 11'(x0 + i);
            step();
        end
        vga_valid = 0;
        step();
        step();
    endtask

    task automatic check_reset_outputs();
        chk("rst_rend_enable", -1, -1, int'(rend_enable), 0);
        chk("rst_offset", -1, -1, int'(char_addr_offset), 0);
        chk("rst_top_left_x", -1, -1, int'(top_left_x), 0);
        chk("rst_top_left_y", -1, -1, int'(top_left_y), 0);
        chk("rst_scale_x_o", -1, -1, int'(scale_x_o), 0);
        chk("rst_scale_y_o", -1, -1, int'(scale_y_o), 0);
        chk("rst_busy", -1, -1, int'(bus.busy), 0);
        chk("rst_commit_ack", -1, -1, int'(bus.commit_ack), 0);
    endtask

    task automatic do_reset();
        #1 rst = 1;
        #1 check_reset_outputs();
        model_reset();
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    int happy[5] = '{8, 1, 16, 16, 25};

    initial begin
        int n, ox, oy, sx, sy, sxe, sye, lenc, y, x0;
        rst = 1;
        bus.wr_en = 0; bus.wr_idx = '0; bus.wr_code = '0;
        bus.cfg_len = '0; bus.cfg_origin_x = '0; bus.cfg_origin_y = '0;
        bus.cfg_scale_x = '0; bus.cfg_scale_y = '0; bus.commit_req = 0;
`ifdef TEXT_BLINK_EN
        bus.cfg_blink = 0;
`endif
        frame_start = 0; vga_x = '0; vga_y = '0; vga_valid = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_reset_outputs();
        @(negedge clk);
        rst = 0;
        step();

        for (int i = 0; i < 4; i++) wr(i, happy[i]);
        bus.wr_en = 1; bus.wr_idx = 4; bus.wr_code = CODE_W'(happy[4]);
        commit(5, 100, 50, 4, 4);
        wr(0, 3);
        commit(3, 0, 0, 1, 1);
        step();
        frame();
        scan(50, 90, 200);
        scan(81, 98, 40);
        scan(82, 95, 200);
        scan(49, 95, 50);

        wr(0, 5);
        commit(1, 0, 0, 1, 1);
        step();
        do_reset();
        frame();
        scan(0, 0, 20);

        for (int i = 0; i < MAX_CHARS; i++) wr(i, int'($urandom_range(0, 63)));
        commit(20, 10, 5, 0, 2);
        frame();
        scan(6, 5, 150);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < MAX_CHARS; i++)
                if ($urandom_range(0, 1) == 1) wr(i, int'($urandom_range(0, 63)));
            n = int'($urandom_range(0, 20));
            ox = int'($urandom_range(0, 300));
            oy = int'($urandom_range(0, 100));
            sx = int'($urandom_range(0, 4));
            sy = int'($urandom_range(0, 3));
            commit(n, ox, oy, sx, sy);
            frame();
            sxe = (sx == 0) ? 1 : sx;
            sye = (sy == 0) ? 1 : sy;
            lenc = (n > 16) ? 16 : n;
            for (int l = 0; l < 3; l++) begin
                y = oy - 1 + int'($urandom_range(0, 8 * sye + 1));
                if (y < 0) y = 0;
                x0 = ox - int'($urandom_range(0, 3));
                if (x0 < 0) x0 = 0;
                if ($urandom_range(0, 5) == 0) x0 = ox + 1;
                scan(y, x0, int'($urandom_range(1, 8 * sxe * lenc + 16)));
            end
        end

`ifdef TEXT_BLINK_EN
        bus.cfg_blink = 1;
        wr(0, 7);
        wr(1, 9);
        commit(2, 0, 0, 1, 1);
        frame();
        for (int f = 0; f < 70; f++) begin
            frame();
            scan(1, 0, 20);
        end
        bus.cfg_blink = 0;
`endif

        step();
        step();
        #1 chk("scoreboard_drain", 0, 0, q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_overlay_ctrl.md
Name: text_overlay_ctrl

Overview:
- Sequences the 8x8 character renderer across a line of text: holds a label string and, per pixel, supplies the current glyph's ROM offset, cell origin and scale.
- Label updates (e.g. a new emotion name) go into a shadow buffer and are committed only at frame start, so text never tears mid-frame.
- Sits between the emotion-result logic / VGA timing and the character renderer.

Parameters:
- MAX_CHARS, 16: label capacity in characters; must be a power of two, 2..32.
- IDX_W, 4: index width, log2(MAX_CHARS).
- CODE_W, 6: glyph code width; 64 glyphs x 8 rows = 512 ROM rows.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write one shadow character
- wr_idx  in  IDX_W  shadow slot index
- wr_code  in  CODE_W  glyph code
- cfg_len  in  IDX_W+1  label length, sampled at commit_req
- cfg_origin_x  in  11  label top-left x, sampled at commit_req
- cfg_origin_y  in  10  label top-left y, sampled at commit_req
- cfg_scale_x  in  4  horizontal scale, sampled at commit_req
- cfg_scale_y  in  4  vertical scale, sampled at commit_req
- commit_req  in  1  request to apply the shadow contents
- commit_ack  out  1  one-cycle pulse when the swap completes
- busy  out  1  commit pending; writes and new requests are ignored
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- vga_x  in  11  pixel x; increments by 1 per valid cycle within a line
- vga_y  in  10  pixel y
- vga_valid  in  1  active-video qualifier
- rend_enable  out  1  renderer enable for this pixel
- char_addr_offset  out  9  glyph code x 8
- top_left_x  out  11  x of the current cell
- top_left_y  out  10  active origin_y
- scale_x_o  out  4  active scale_x
- scale_y_o  out  4  active scale_y

Behaviour:
- Reset:
  - All outputs 0.
  - FSM in IDLE.
  - Active and shadow buffers cleared to code 0.
  - Active len = 0; active scales = 1.
- Config sanitising at sample time:
  - A scale of 0 is stored as 1.
  - cfg_len > MAX_CHARS is clamped to MAX_CHARS.
- Commit FSM:
  - IDLE: wr_en writes shadow[wr_idx]. commit_req latches cfg_* and moves to ARMED. If wr_en and commit_req arrive in the same cycle, the write lands first and is included.
  - ARMED (busy=1): on frame_start -> SWAP.
  - SWAP (busy=1, one cycle): shadow and cfg copy into the active registers; commit_ack=1 in the next cycle; return to IDLE.
  - commit_req while busy is ignored, not queued. wr_en while busy is ignored.
  - A frame_start arriving in the same cycle as commit_req does not swap; the swap waits for the next frame_start.
- Cell scan (all outputs registered; outputs at cycle n+1 reflect inputs at cycle n; VGA timing delays the renderer's coordinates by one cycle):
  - Row band: vga_y in [origin_y, origin_y + 8*scale_y).
  - When vga_valid and vga_x == origin_x inside the band: col=0, sub=0, cell_x=origin_x, running=1.
  - Each subsequent valid cycle: sub++. When sub == 8*scale_x-1: sub=0, col++, cell_x += 8*scale_x.
  - When col reaches len, or vga_valid drops: running=0 until the next line's origin match.
  - rend_enable = running && col < len && band.
  - char_addr_offset = active[col] << 3.
  - top_left_x = cell_x.
  - When rend_enable=0: char_addr_offset=0 and top_left_x=origin_x.
- Edge cases:
  - len=0: rend_enable never asserts.
  - Labels that overrun the screen width are truncated by vga_valid; no wrap to the next line.
- Swap timing: active registers change only in SWAP, which follows frame_start (blanking), so an active line is never disturbed.

Optional Feature:
- Macro TEXT_BLINK_EN.
- When defined:
  - Adds input cfg_blink (sampled with commit).
  - Adds a 6-bit frame counter, incremented on each frame_start and cleared on reset.
  - While active blink=1, rend_enable is forced 0 when counter bit 5 is 1, giving 32 frames on and 32 off.
- When undefined: no port, no counter; behaviour exactly as above.

Decomposition:
- Package text_overlay_pkg holds:
  - CHAR_W=8, CHAR_H=8, MAX_CHARS, IDX_W, CODE_W
  - commit FSM state encoding (IDLE, ARMED, SWAP)
  - clamp/scale-fix helper constants
- Natural sub-module cell_scan_counter holds the sub/col/cell_x stepper. The top level keeps the buffers and the commit FSM.

Test Plan:
- Reset mid-ARMED, then release -> FSM IDLE, busy=0, no commit_ack, rend_enable=0 on the next frame.
- Write "HAPPY" (codes 8,1,16,16,25) to slots 0-4; commit_req with len=5, origin (100,50), scale 4/4; pulse frame_start -> commit_ack 2 cycles later. On line y=50:
  - x=100..131: offset 64, top_left_x=100.
  - x=132..163: offset 8, top_left_x=132.
  - x=260: enable 0.
- wr_en slot 0 code 3 while ARMED -> ignored; after swap, slot 0 still holds 8.
- cfg_len=20, scale_x=0 -> clamped to 16 chars at width 8; cell boundaries every 8 pixels; col 16 gives enable 0.
- y=82, just below the band (50+32) -> rend_enable=0 for the whole line.
- TEXT_BLINK_EN, blink=1 -> enable suppressed for frames 32-63, restored at frame 64.
